// File: rtl/h2h_lbus_bridge_if.sv
// Bus bundle between the h2h AHB-Lite master port and the local-bus bridge.
// The slave modport is the bridge side; master is the bus/peripheral side.
interface h2h_lbus_bridge_if #(
   parameter int NUM_CH = 4,
   parameter int CH_AW  = 12
);
   logic [31:0]          h2h_haddr;
   logic [1:0]           h2h_htrans;
   logic                 h2h_hwrite;
   logic [2:0]           h2h_hsize;
   logic [31:0]          h2h_hwdata;
   logic [31:0]          h2h_hrdata;
   logic                 h2h_hreadyout;
   logic [1:0]           h2h_hresp;
   logic [NUM_CH-1:0]    lb_req;
   logic                 lb_wr;
   logic [CH_AW-1:0]     lb_addr;
   logic [31:0]          lb_wdata;
   logic [3:0]           lb_be;
   logic [NUM_CH-1:0]    lb_ack;
   logic [NUM_CH*32-1:0] lb_rdata;

   modport slave (
      input  h2h_haddr, h2h_htrans, h2h_hwrite, h2h_hsize, h2h_hwdata, lb_ack, lb_rdata,
      output h2h_hrdata, h2h_hreadyout, h2h_hresp, lb_req, lb_wr, lb_addr, lb_wdata, lb_be
   );

   modport master (
      output h2h_haddr, h2h_htrans, h2h_hwrite, h2h_hsize, h2h_hwdata, lb_ack, lb_rdata,
      input  h2h_hrdata, h2h_hreadyout, h2h_hresp, lb_req, lb_wr, lb_addr, lb_wdata, lb_be
   );
endinterface

// File: rtl/h2h_lbus_bridge.sv
// AHB-Lite slave decoding h2h transfers onto NUM_CH req/ack local-bus channels.
// Define H2H_TIMEOUT_EN to abort a REQ phase with ERROR after TIMEOUT cycles without ack.
module h2h_lbus_bridge #(
   parameter int          NUM_CH    = 4,
   parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
   parameter int          CH_AW     = 12,
   parameter int          TIMEOUT   = 255
) (
   input logic              h2h_mclk,
   input logic              h2h_rst,
   h2h_lbus_bridge_if.slave bus
);
   localparam int CH_BITS = $clog2(NUM_CH);
   localparam int CHW     = (CH_BITS == 0) ? 1 : CH_BITS;
   localparam int DEC_SH  = CH_AW + CH_BITS;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b01;

   typedef enum logic [2:0] {IDLE, DATA, REQ, DONE, ERR1, ERR2} state_t;

   state_t           state;
   logic [CHW-1:0]   ch_q;
   logic [CHW-1:0]   ch_d;
   logic             wr_q;
   logic [CH_AW-1:0] off_q;
   logic [3:0]       be_q;
   logic             accept;
   logic             bad_d;

`ifdef H2H_TIMEOUT_EN
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int CNT_W = (TW < 8) ? 8 : ((TW > 16) ? 16 : TW);
   logic [CNT_W-1:0] tmo_cnt;
`endif

   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
      case (size)
         3'd0:    byte_en = 4'b0001 << a;
         3'd1:    byte_en = 4'b0011 << {a[1], 1'b0};
         default: byte_en = 4'hF;
      endcase
   endfunction

   // Channel indices past NUM_CH (non power-of-two counts) are treated as unmapped.
   always_comb begin
      accept = bus.h2h_hreadyout && (bus.h2h_htrans == 2'b10 || bus.h2h_htrans == 2'b11);
      ch_d   = (CH_BITS == 0) ? '0 : CHW'(bus.h2h_haddr >> CH_AW);
      bad_d  = ((bus.h2h_haddr >> DEC_SH) != (BASE_ADDR >> DEC_SH))
            || (int'(ch_d) >= NUM_CH)
            || (bus.h2h_hsize > 3'd2)
            || (bus.h2h_hsize == 3'd1 && bus.h2h_haddr[0])
            || (bus.h2h_hsize == 3'd2 && bus.h2h_haddr[1:0] != 2'b00);
   end

   always_ff @(posedge h2h_mclk) begin
      if (h2h_rst) begin
         state             <= IDLE;
         bus.h2h_hreadyout <= 1'b1;
         bus.h2h_hresp     <= RESP_OKAY;
         bus.h2h_hrdata    <= '0;
         bus.lb_req        <= '0;
         bus.lb_wr         <= 1'b0;
         bus.lb_addr       <= '0;
         bus.lb_wdata      <= '0;
         bus.lb_be         <= '0;
         ch_q              <= '0;
         wr_q              <= 1'b0;
         off_q             <= '0;
         be_q              <= '0;
`ifdef H2H_TIMEOUT_EN
         tmo_cnt           <= '0;
`endif
      end else begin
         case (state)
            // Address-phase capable states: hreadyout is high here.
            IDLE, DONE, ERR2: begin
               state             <= IDLE;
               bus.h2h_hreadyout <= 1'b1;
               bus.h2h_hresp     <= RESP_OKAY;
               if (accept) begin
                  ch_q              <= ch_d;
                  wr_q              <= bus.h2h_hwrite;
                  off_q             <= bus.h2h_haddr[CH_AW-1:0];
                  be_q              <= byte_en(bus.h2h_hsize, bus.h2h_haddr[1:0]);
                  bus.h2h_hreadyout <= 1'b0;
                  if (bad_d) begin
                     state         <= ERR1;
                     bus.h2h_hresp <= RESP_ERR;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               bus.lb_wdata <= bus.h2h_hwdata;
               bus.lb_req   <= NUM_CH'(1) << ch_q;
               bus.lb_wr    <= wr_q;
               bus.lb_addr  <= off_q;
               bus.lb_be    <= be_q;
`ifdef H2H_TIMEOUT_EN
               tmo_cnt      <= '0;
`endif
               state        <= REQ;
            end
            REQ: begin
               if (bus.lb_ack[ch_q]) begin
                  bus.lb_req        <= '0;
                  bus.h2h_hreadyout <= 1'b1;
                  bus.h2h_hresp     <= RESP_OKAY;
                  if (!wr_q) bus.h2h_hrdata <= bus.lb_rdata[32*int'(ch_q) +: 32];
                  state             <= DONE;
               end
`ifdef H2H_TIMEOUT_EN
               else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                  bus.lb_req    <= '0;
                  bus.h2h_hresp <= RESP_ERR;
                  state         <= ERR1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            ERR1: begin
               bus.h2h_hreadyout <= 1'b1;
               bus.h2h_hresp     <= RESP_ERR;
               state             <= ERR2;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_h2h_lbus_bridge.sv
// Directed scoreboard bench for h2h_lbus_bridge (NUM_CH=4, CH_AW=12, TIMEOUT=255).
// Expected transfers are queued at address phase and retired when the data phase completes.
module tb_h2h_lbus_bridge;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   int   fails = 0;

   h2h_lbus_bridge_if #(.NUM_CH(4), .CH_AW(12)) bus ();

   h2h_lbus_bridge #(
      .NUM_CH(4), .BASE_ADDR(32'h6000_0000), .CH_AW(12), .TIMEOUT(255)
   ) dut (
      .h2h_mclk(clk),
      .h2h_rst (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          err;
      logic [3:0]  req;
      logic [11:0] addr;
      logic [3:0]  be;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      int          reqcyc;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t mk(bit err, logic [3:0] req, logic [11:0] addr, logic [3:0] be,
                               logic wr, logic [31:0] wdata, logic [31:0] rdata,
                               int waits, int reqcyc);
      exp_t e;
      e.err = err; e.req = req; e.addr = addr; e.be = be; e.wr = wr;
      e.wdata = wdata; e.rdata = rdata; e.waits = waits; e.reqcyc = reqcyc;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz, input exp_t e);
      bus.h2h_haddr  = a;
      bus.h2h_hwrite = w;
      bus.h2h_hsize  = sz;
      bus.h2h_htrans = 2'b10;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle_rdy", 32'(bus.h2h_hreadyout), 32'd1);
      end
   endtask

   // Runs the data phase of the oldest queued transfer; dly<0 never acks.
   task automatic data_phase(input logic [31:0] wd, input int dly, input logic [31:0] rd,
                             input logic [3:0] noise, input int limit, output bit done);
      exp_t e;
      int   ch;
      int   waits;
      int   seen;
      e = sb[0];
      ch = 0;
      for (int i = 0; i < 4; i++) if (e.req[i]) ch = i;
      @(negedge clk);
      bus.h2h_htrans = 2'b00;
      bus.h2h_hwdata = wd;
      bus.lb_rdata   = {4{32'hBAD0_BAD0}};
      bus.lb_rdata[32*ch +: 32] = rd;
      done  = 1'b0;
      waits = 0;
      seen  = 0;
      for (int c = 0; c < limit; c++) begin
         if (c == 0) chk("dphase_hresp", 32'(bus.h2h_hresp), (e.err && e.reqcyc == 0) ? 32'd1 : 32'd0);
         if (bus.lb_req !== 4'b0000) begin
            if (seen == 0) begin
               chk("req_latency", 32'(c), 32'd1);
               chk("lb_req", 32'(bus.lb_req), 32'(e.req));
               chk("lb_addr", 32'(bus.lb_addr), 32'(e.addr));
               chk("lb_be", 32'(bus.lb_be), 32'(e.be));
               chk("lb_wr", 32'(bus.lb_wr), 32'(e.wr));
               if (e.wr) chk("lb_wdata", bus.lb_wdata, e.wdata);
            end
            seen++;
         end
         bus.lb_ack = noise;
         if (bus.lb_req !== 4'b0000 && dly >= 0 && seen == dly + 1) bus.lb_ack = noise | e.req;
         if (bus.h2h_hreadyout === 1'b1) begin
            done = 1'b1;
            void'(sb.pop_front());
            chk("hresp", 32'(bus.h2h_hresp), e.err ? 32'd1 : 32'd0);
            chk("hrdata", bus.h2h_hrdata, e.rdata);
            chk("wait_states", 32'(waits), 32'(e.waits));
            chk("req_cycles", 32'(seen), 32'(e.reqcyc));
            chk("req_dropped", 32'(bus.lb_req), 32'd0);
            bus.lb_ack = 4'b0000;
            break;
         end
         waits++;
         @(negedge clk);
      end
      bus.lb_ack = 4'b0000;
   endtask

   initial begin
      bit done;
      bus.h2h_haddr  = '0;
      bus.h2h_htrans = 2'b00;
      bus.h2h_hwrite = 1'b0;
      bus.h2h_hsize  = 3'd0;
      bus.h2h_hwdata = '0;
      bus.lb_ack     = '0;
      bus.lb_rdata   = '0;
      repeat (2) @(negedge clk);
      chk("rst_hreadyout", 32'(bus.h2h_hreadyout), 32'd1);
      chk("rst_hresp", 32'(bus.h2h_hresp), 32'd0);
      chk("rst_hrdata", bus.h2h_hrdata, 32'd0);
      chk("rst_lb_req", 32'(bus.lb_req), 32'd0);
      chk("rst_lb_wr", 32'(bus.lb_wr), 32'd0);
      chk("rst_lb_addr", 32'(bus.lb_addr), 32'd0);
      chk("rst_lb_wdata", bus.lb_wdata, 32'd0);
      chk("rst_lb_be", 32'(bus.lb_be), 32'd0);
      rst = 1'b0;
      idle(2);

      // Word write ch1, immediate ack
      issue(32'h6000_1004, 1'b1, 3'd2, mk(0, 4'b0010, 12'h004, 4'hF, 1'b1, 32'hDEAD_BEEF, 32'h0, 2, 1));
      data_phase(32'hDEAD_BEEF, 0, 32'h0, 4'b0000, 20, done);
      chk("t1_done", 32'(done), 32'd1);
      idle(2);

      // Byte read ch0, ack after 5 cycles
      issue(32'h6000_0003, 1'b0, 3'd0, mk(0, 4'b0001, 12'h003, 4'b1000, 1'b0, 32'h0, 32'hA1B2_C3D4, 7, 6));
      data_phase(32'h0, 5, 32'hA1B2_C3D4, 4'b0000, 20, done);
      chk("t2_done", 32'(done), 32'd1);
      idle(1);

      // Halfword read ch2 with acks toggling on the other channels
      issue(32'h6000_2802, 1'b0, 3'd1, mk(0, 4'b0100, 12'h802, 4'b1100, 1'b0, 32'h0, 32'h1234_5678, 4, 3));
      data_phase(32'h0, 2, 32'h1234_5678, 4'b1011, 20, done);
      chk("t3_done", 32'(done), 32'd1);
      idle(1);

      // Error cases chained back-to-back through ERR2
      issue(32'h7000_0000, 1'b0, 3'd2, mk(1, 4'b0, 12'h0, 4'h0, 1'b0, 32'h0, 32'h1234_5678, 1, 0));
      data_phase(32'h0, 0, 32'h0, 4'b0000, 20, done);
      issue(32'h6000_0001, 1'b0, 3'd1, mk(1, 4'b0, 12'h0, 4'h0, 1'b0, 32'h0, 32'h1234_5678, 1, 0));
      data_phase(32'h0, 0, 32'h0, 4'b0000, 20, done);
      issue(32'h6000_0000, 1'b1, 3'd3, mk(1, 4'b0, 12'h0, 4'h0, 1'b0, 32'h0, 32'h1234_5678, 1, 0));
      data_phase(32'h0, 0, 32'h0, 4'b0000, 20, done);
      issue(32'h6000_3002, 1'b0, 3'd2, mk(1, 4'b0, 12'h0, 4'h0, 1'b0, 32'h0, 32'h1234_5678, 1, 0));
      data_phase(32'h0, 0, 32'h0, 4'b0000, 20, done);
      // Valid write accepted during ERR2
      issue(32'h6000_3FFC, 1'b1, 3'd2, mk(0, 4'b1000, 12'hFFC, 4'hF, 1'b1, 32'hCAFE_F00D, 32'h1234_5678, 3, 2));
      data_phase(32'hCAFE_F00D, 1, 32'h0, 4'b0000, 20, done);
      chk("t8_done", 32'(done), 32'd1);

      // Back-to-back writes ch2, ch3, ch1 byte, then ch3 halfword read
      issue(32'h6000_2010, 1'b1, 3'd2, mk(0, 4'b0100, 12'h010, 4'hF, 1'b1, 32'h1111_2222, 32'h1234_5678, 2, 1));
      data_phase(32'h1111_2222, 0, 32'h0, 4'b0000, 20, done);
      issue(32'h6000_3008, 1'b1, 3'd2, mk(0, 4'b1000, 12'h008, 4'hF, 1'b1, 32'h3333_4444, 32'h1234_5678, 2, 1));
      data_phase(32'h3333_4444, 0, 32'h0, 4'b0000, 20, done);
      issue(32'h6000_1002, 1'b1, 3'd0, mk(0, 4'b0010, 12'h002, 4'b0100, 1'b1, 32'h00AB_0000, 32'h1234_5678, 3, 2));
      data_phase(32'h00AB_0000, 1, 32'h0, 4'b0000, 20, done);
      issue(32'h6000_3FFE, 1'b0, 3'd1, mk(0, 4'b1000, 12'hFFE, 4'b1100, 1'b0, 32'h0, 32'h55AA_66BB, 2, 1));
      data_phase(32'h0, 0, 32'h55AA_66BB, 4'b0111, 20, done);
      chk("b2b_done", 32'(done), 32'd1);
      idle(1);

      // BUSY in IDLE: zero-wait OKAY, no request
      bus.h2h_haddr  = 32'h6000_0000;
      bus.h2h_htrans = 2'b01;
      @(negedge clk);
      chk("busy_rdy", 32'(bus.h2h_hreadyout), 32'd1);
      chk("busy_resp", 32'(bus.h2h_hresp), 32'd0);
      chk("busy_req", 32'(bus.lb_req), 32'd0);
      bus.h2h_htrans = 2'b00;
      idle(1);

`ifdef H2H_TIMEOUT_EN
      issue(32'h6000_0100, 1'b0, 3'd2, mk(1, 4'b0001, 12'h100, 4'hF, 1'b0, 32'h0, 32'h55AA_66BB, 257, 255));
      data_phase(32'h0, -1, 32'h0, 4'b0000, 400, done);
      chk("tmo_done", 32'(done), 32'd1);
      issue(32'h6000_0200, 1'b0, 3'd2, mk(0, 4'b0001, 12'h200, 4'hF, 1'b0, 32'h0, 32'h0, 0, 0));
      data_phase(32'h0, -1, 32'h0, 4'b0000, 4, done);
`else
      issue(32'h6000_0100, 1'b0, 3'd2, mk(0, 4'b0001, 12'h100, 4'hF, 1'b0, 32'h0, 32'h0, 0, 0));
      data_phase(32'h0, -1, 32'h0, 4'b0000, 1000, done);
`endif
      chk("hang_done", 32'(done), 32'd0);
      chk("hang_req", 32'(bus.lb_req), 32'd1);
      chk("hang_rdy", 32'(bus.h2h_hreadyout), 32'd0);
      sb.delete();

      // Reset while in REQ, then a late ack
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_req", 32'(bus.lb_req), 32'd0);
      chk("mrst_rdy", 32'(bus.h2h_hreadyout), 32'd1);
      chk("mrst_resp", 32'(bus.h2h_hresp), 32'd0);
      chk("mrst_hrdata", bus.h2h_hrdata, 32'd0);
      chk("mrst_wdata", bus.lb_wdata, 32'd0);
      chk("mrst_be", 32'(bus.lb_be), 32'd0);
      chk("mrst_addr", 32'(bus.lb_addr), 32'd0);
      rst = 1'b0;
      bus.lb_ack = 4'b0001;
      bus.lb_rdata = {4{32'hFEED_FACE}};
      @(negedge clk);
      bus.lb_ack = 4'b0000;
      chk("late_ack_req", 32'(bus.lb_req), 32'd0);
      chk("late_ack_rdy", 32'(bus.h2h_hreadyout), 32'd1);
      chk("late_ack_hrdata", bus.h2h_hrdata, 32'd0);
      idle(2);
      chk("end_hrdata", bus.h2h_hrdata, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/h2h_lbus_bridge.md
# h2h_lbus_bridge

Parametrised AHB-Lite slave for the Cortex-M3 hard core's h2h master port. It decodes h2h transfers into NUM_CH local-bus channels with a req/ack handshake, byte enables and variable wait states. It returns an AHB ERROR response for unmapped, misaligned or unsupported accesses. It sits in fabric directly on the MCU's h2h_* pins and fans out to peripheral register blocks.

## Interface
Parameters:
- NUM_CH, 4: number of local-bus channels, 1..16.
- BASE_ADDR, 32'h6000_0000: window base; must be aligned to NUM_CH<<CH_AW.
- CH_AW, 12: address bits per channel (each channel is a 2^CH_AW-byte window).
- TIMEOUT, 255: maximum ack wait in cycles. Used only when H2H_TIMEOUT_EN is defined.

Ports:
- h2h_mclk, in, 1: clock. All logic is on the rising edge.
- h2h_rst, in, 1: reset, synchronous and active-high.
- h2h_haddr, in, 32: AHB address.
- h2h_htrans, in, 2: AHB transfer type.
- h2h_hwrite, in, 1: AHB write flag.
- h2h_hsize, in, 3: AHB transfer size.
- h2h_hwdata, in, 32: AHB write data.
- h2h_hrdata, out, 32: AHB read data.
- h2h_hreadyout, out, 1: AHB ready. This is also the bus HREADY (single master, single slave).
- h2h_hresp, out, 2: 2'b00 OKAY, 2'b01 ERROR.
- lb_req, out, NUM_CH: one-hot request, held until ack.
- lb_wr, out, 1: 1 = write.
- lb_addr, out, CH_AW: byte offset within the channel.
- lb_wdata, out, 32: write data.
- lb_be, out, 4: byte enables.
- lb_ack, in, NUM_CH: per-channel acknowledge.
- lb_rdata, in, NUM_CH*32: per-channel read data; channel n occupies [32n+31:32n].

## Operation
- FSM states: IDLE, DATA, REQ, DONE, ERR1, ERR2.
- Address phase is accepted when h2h_htrans[1]=1 and h2h_hreadyout=1, in either IDLE or DONE. On acceptance the block registers addr, hwrite and hsize and decodes.
- Decode:
  - In range when haddr[31:CH_AW+clog2(NUM_CH)] equals the same bits of BASE_ADDR.
  - ch = haddr[CH_AW+clog2(NUM_CH)-1:CH_AW].
  - NUM_CH=1 uses ch=0.
- ERROR conditions, any of:
  - address out of range;
  - hsize>2;
  - halfword with haddr[0]=1;
  - word with haddr[1:0]!=0.
- ERROR handling: go to ERR1 (hreadyout=0, hresp=01), then ERR2 (hreadyout=1, hresp=01), then IDLE. No lb_req is raised. A transfer presented during ERR2 is accepted as a normal address phase.
- Valid transfer path:
  - IDLE/DONE → DATA: hreadyout=0; h2h_hwdata is registered into lb_wdata at the end of DATA.
  - DATA → REQ: lb_req[ch]=1; lb_wr, lb_addr and lb_be are stable.
  - REQ → DONE: on lb_ack[ch]=1. For a read, lb_rdata slice ch is registered into h2h_hrdata. lb_req drops.
  - DONE: hreadyout=1, hresp=00. Next state is DATA if a new transfer is accepted, otherwise IDLE.
- Byte enables:
  - byte: 4'b0001<<haddr[1:0]
  - half: 4'b0011<<{haddr[1],1'b0}
  - word: 4'hF
- IDLE or BUSY htrans in IDLE/DONE: no action, zero-wait OKAY.
- lb_ack bits for non-selected channels, and any ack outside REQ, are ignored.
- h2h_hrdata holds its last read value across writes and idle cycles.
- Reset values: h2h_hreadyout=1, h2h_hresp=00, h2h_hrdata=0, lb_req=0, lb_wr=0, lb_addr=0, lb_wdata=0, lb_be=0, state IDLE.
- Reset asserted mid-transfer forces every reset value at the next edge. The pending request is abandoned and a late ack is ignored.

## Timing
- Address phase accepted in cycle 0, ack in the same cycle req rises:
  - hreadyout=0 in cycles 1 and 2;
  - hreadyout=1 with data/OKAY in cycle 3.
  - Minimum data phase is 3 cycles (2 wait states).
- Each cycle of ack delay adds one wait state.
- lb_req rises 2 cycles after the address phase. It falls the cycle after lb_ack is sampled high.
- Back-to-back transfers: a new address accepted in DONE yields a DATA state in the next cycle, with no idle bubble.
- ERROR response always takes exactly 2 cycles (ERR1, ERR2).

## Configuration
- Macro: H2H_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entering REQ and increments each REQ cycle.
  - When it reaches TIMEOUT with no ack, lb_req drops and the FSM goes to ERR1/ERR2.
  - An ack in the same cycle as the timeout wins (OKAY).
- Not defined: REQ waits indefinitely for ack; no counter logic is present.

## Test plan
- Word write to 0x6000_1004, ch1 acks immediately → lb_req=4'b0010, lb_addr=0x004, lb_be=4'hF, lb_wdata equals the bus data; hreadyout low 2 cycles, then OKAY.
- Byte read at 0x6000_0003, ch0 acks after 5 cycles with 0xA1B2C3D4 → lb_be=4'b1000, 7 wait states, h2h_hrdata=0xA1B2C3D4.
- Access to 0x7000_0000, then a halfword at 0x6000_0001 → each gives two-cycle ERROR (01), with lb_req remaining 0.
- Back-to-back NONSEQ word writes to ch2 then ch3 → second lb_req rises 2 cycles after the first DONE with no IDLE cycle; correct data on each.
- Timeout, with macro defined and TIMEOUT=255: ch0 never acks → lb_req high 255 cycles, then ERROR; without the macro, still waiting after 1000 cycles.
- Reset asserted while in REQ → next edge lb_req=0 and hreadyout=1; an ack 1 cycle later causes no response.
